// File: rtl/fir_tdm_packetizer.sv
// fir_tdm_packetizer: snapshots NUM_CH parallel samples and emits them as one
// Avalon-ST packet, one channel per beat, tagged {channel index, sample}.
//
// Ports:
//   CLOCK_50      clock, rising edge
//   reset         synchronous, active-high
//   sample_valid  one-cycle strobe qualifying channel_data
//   channel_data  flattened samples, channel k at [k*DATA_W +: DATA_W]
//   out_ready     sink ready (ready latency 0)
//   output_data   {channel index, sample}
//   output_valid  beat valid
//   sop / eop     first / last beat of a packet
//   busy          packet in flight or pending frame held
//   overrun       one-cycle pulse when a sample set is dropped
//   drop_count    saturating count of dropped sample sets
//
// Build option: define FIR_TDM_PENDING_EN to add a one-deep pending frame
// buffer; without it, a strobe mid-packet (other than on the eop-accept
// cycle) is dropped.
module fir_tdm_packetizer #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] channel_data,
    input  logic                     out_ready,
    output logic [CH_W+DATA_W-1:0]   output_data,
    output logic                     output_valid,
    output logic                     sop,
    output logic                     eop,
    output logic                     busy,
    output logic                     overrun,
    output logic [15:0]              drop_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]               state, n_state;
    logic [CH_W-1:0]          ch_idx, n_idx;
    logic [NUM_CH*DATA_W-1:0] active, n_active;
    logic                     eop_acc, drop;
`ifdef FIR_TDM_PENDING_EN
    logic [NUM_CH*DATA_W-1:0] pending, n_pending;
    logic                     pend_full, n_pend_full;
`endif

    // Next-state values feed the output registers directly, so every output
    // is registered yet reflects the beat for the coming cycle.
    always_comb begin
        eop_acc  = state == SEND && out_ready && eop;
        n_state  = state;
        n_idx    = ch_idx;
        n_active = active;
        drop     = 1'b0;
`ifdef FIR_TDM_PENDING_EN
        n_pending   = pending;
        n_pend_full = pend_full;
`endif
        if (state == IDLE) begin
            if (sample_valid) begin
                n_state  = SEND;
                n_idx    = '0;
                n_active = channel_data;
            end
        end else if (eop_acc) begin
            n_idx = '0;
`ifdef FIR_TDM_PENDING_EN
            if (pend_full) begin
                n_active    = pending;
                n_pend_full = sample_valid;
                n_pending   = sample_valid ? channel_data : pending;
            end else if (sample_valid) begin
                n_active = channel_data;
            end else begin
                n_state = IDLE;
            end
`else
            if (sample_valid) n_active = channel_data;
            else n_state = IDLE;
`endif
        end else begin
            if (out_ready) n_idx = ch_idx + CH_W'(1);
`ifdef FIR_TDM_PENDING_EN
            if (sample_valid && !pend_full) begin
                n_pending   = channel_data;
                n_pend_full = 1'b1;
            end else begin
                drop = sample_valid;
            end
`else
            drop = sample_valid;
`endif
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            ch_idx       <= '0;
            active       <= '0;
            output_valid <= 1'b0;
            sop          <= 1'b0;
            eop          <= 1'b0;
            output_data  <= '0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            drop_count   <= '0;
`ifdef FIR_TDM_PENDING_EN
            pending      <= '0;
            pend_full    <= 1'b0;
`endif
        end else begin
            state        <= n_state;
            ch_idx       <= n_idx;
            active       <= n_active;
            output_valid <= n_state == SEND;
            sop          <= n_state == SEND && n_idx == '0;
            eop          <= n_state == SEND && n_idx == CH_W'(NUM_CH - 1);
            output_data  <= n_state == SEND ? {n_idx, n_active[n_idx*DATA_W +: DATA_W]} : '0;
            overrun      <= drop;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`ifdef FIR_TDM_PENDING_EN
            pending      <= n_pending;
            pend_full    <= n_pend_full;
            busy         <= n_state == SEND || n_pend_full;
`else
            busy         <= n_state == SEND;
`endif
        end
    end
endmodule

// File: tb/tb_fir_tdm_packetizer.sv
// tb_fir_tdm_packetizer: randomized self-checking bench for fir_tdm_packetizer
// against a frame-queue reference model.
module tb_fir_tdm_packetizer;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 16;
    localparam int CH_W   = 3;
    localparam int FW     = NUM_CH * DATA_W;
    localparam int VW     = 5 + 16 + CH_W + DATA_W;
`ifdef FIR_TDM_PENDING_EN
    localparam int DEPTH = 1;
`else
    localparam int DEPTH = 0;
`endif

    logic                   CLOCK_50 = 1'b0;
    logic                   reset = 1'b1;
    logic                   sample_valid = 1'b0;
    logic [FW-1:0]          channel_data = '0;
    logic                   out_ready = 1'b1;
    logic [CH_W+DATA_W-1:0] output_data;
    logic                   output_valid, sop, eop, busy, overrun;
    logic [15:0]            drop_count;

    int checks = 0;
    int failures = 0;

    fir_tdm_packetizer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .sample_valid(sample_valid),
        .channel_data(channel_data), .out_ready(out_ready),
        .output_data(output_data), .output_valid(output_valid), .sop(sop),
        .eop(eop), .busy(busy), .overrun(overrun), .drop_count(drop_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model: the frame being sent plus a FIFO of waiting frames
    // whose capacity is the pending depth.
    logic [FW-1:0] m_cur;
    bit            m_cur_v;
    int            m_pos;
    logic [FW-1:0] m_q[$];
    int            m_drops;
    bit            m_ovr;

    function automatic logic [VW-1:0] exp_vec();
        logic [CH_W+DATA_W-1:0] d;
        d = m_cur_v ? {CH_W'(m_pos), m_cur[m_pos*DATA_W +: DATA_W]} : '0;
        return {m_cur_v, m_cur_v && m_pos == 0, m_cur_v && m_pos == NUM_CH - 1,
                m_cur_v || m_q.size() > 0, m_ovr, 16'(m_drops), d};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {output_valid, sop, eop, busy, overrun, drop_count, output_data};
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return f;
    endfunction

    task automatic drive_cycle(input logic r, input logic sv, input logic [FW-1:0] d, input logic rdy);
        reset = r;
        sample_valid = sv;
        channel_data = d;
        out_ready = rdy;
        @(posedge CLOCK_50);
        #1;
        if (r) begin
            m_cur_v = 0; m_pos = 0; m_q.delete(); m_drops = 0; m_ovr = 0;
        end else begin
            m_ovr = 0;
            if (m_cur_v && rdy) begin
                if (m_pos == NUM_CH - 1) m_cur_v = 0;
                else m_pos++;
            end
            if (!m_cur_v && m_q.size() > 0) begin
                m_cur = m_q.pop_front(); m_cur_v = 1; m_pos = 0;
            end
            if (sv) begin
                if (!m_cur_v) begin
                    m_cur = d; m_cur_v = 1; m_pos = 0;
                end else if (m_q.size() < DEPTH) begin
                    m_q.push_back(d);
                end else begin
                    m_ovr = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
        reset = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, $urandom_range(0, 1), rand_frame(), 1);
            if (act_vec() !== '0) begin
                failures++;
                $display("FAIL reset_state got=%h exp=0", act_vec());
            end
            checks++;
        end
    endtask

    task automatic test_ready_path();
        logic [FW-1:0] f;
        int beats = 0;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = 16'h1000 + 16'(k);
        drive_cycle(0, 1, f, 1);
        for (int i = 0; i < NUM_CH + 2; i++) begin
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ready_path cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
            checks++;
            if (i < NUM_CH) begin
                if (output_data !== {CH_W'(i), 16'h1000 + 16'(i)} || output_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL ready_beat k=%0d got=%h exp=%h", i, output_data, {CH_W'(i), 16'h1000 + 16'(i)});
                end
                checks++;
            end
            if (output_valid) beats++;
            drive_cycle(0, 0, '0, 1);
        end
        if (beats != NUM_CH) begin
            failures++;
            $display("FAIL ready_len got=%0d exp=%0d", beats, NUM_CH);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        int stalls = 0, len = 0;
        drive_cycle(0, 1, rand_frame(), 1);
        for (int i = 0; i < 16; i++) begin
            logic rdy;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
            checks++;
            if (output_valid) len++;
            rdy = !(m_cur_v && m_pos == 4 && stalls < 3);
            if (!rdy) stalls++;
            drive_cycle(0, 0, '0, rdy);
        end
        if (len != NUM_CH + 3) begin
            failures++;
            $display("FAIL backpressure_len got=%0d exp=%0d", len, NUM_CH + 3);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int sops = 0, valids = 0, pkt = 0;
        drive_cycle(0, 1, rand_frame(), 1);
        for (int i = 0; i < 3 * NUM_CH + 3; i++) begin
            logic sv;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
            checks++;
            if (sop) sops++;
            if (output_valid) valids++;
            sv = (sops == 1 && output_valid && (m_pos == 2 || m_pos == NUM_CH - 1));
            drive_cycle(0, sv, rand_frame(), 1);
        end
        pkt = DEPTH ? 3 : 2;
        if (sops != pkt || valids != pkt * NUM_CH) begin
            failures++;
            $display("FAIL back_to_back_count got=%0d/%0d exp=%0d/%0d", sops, valids, pkt, pkt * NUM_CH);
        end
        checks++;
    endtask

    task automatic test_overrun();
        int base, pulses = 0;
        base = m_drops;
        drive_cycle(0, 1, rand_frame(), 1);
        for (int i = 0; i < NUM_CH + 1; i++) begin
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL overrun cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
            checks++;
            if (overrun) pulses++;
            drive_cycle(0, i == 2 || i == 4, rand_frame(), 1);
        end
        for (int i = 0; i < 2 * NUM_CH; i++) drive_cycle(0, 0, '0, 1);
        if (pulses != (DEPTH ? 1 : 2) || int'(drop_count) != base + (DEPTH ? 1 : 2)) begin
            failures++;
            $display("FAIL overrun_count got=%0d/%0d exp=%0d/%0d", pulses, drop_count, DEPTH ? 1 : 2, base + (DEPTH ? 1 : 2));
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        drive_cycle(0, 1, rand_frame(), 1);
        for (int i = 0; i < 5; i++) drive_cycle(0, 0, '0, 1);
        if (output_data[DATA_W +: CH_W] !== 3'd5 || output_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_beat got=%h exp=beat5", output_data);
        end
        checks++;
        drive_cycle(1, 0, '0, 1);
        if (act_vec() !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=0", act_vec());
        end
        checks++;
        drive_cycle(0, 1, rand_frame(), 1);
        if (act_vec() !== exp_vec() || sop !== 1'b1 || output_data[DATA_W +: CH_W] !== '0) begin
            failures++;
            $display("FAIL reset_restart got=%h exp=%h", act_vec(), exp_vec());
        end
        checks++;
        for (int i = 0; i < NUM_CH + 1; i++) drive_cycle(0, 0, '0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                        rand_frame(), $urandom_range(0, 3) != 0);
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        m_cur = '0; m_cur_v = 0; m_pos = 0; m_drops = 0; m_ovr = 0;
        test_reset();
        test_ready_path();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
